fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch sequencer for the pipelined MIPS core. It owns the program counter and drives the instruction-memory request/acknowledge handshake, tolerating variable memory latency. It presents one fetched instruction to decode through a single-entry IF/ID buffer, which holds while decode asserts hazard. Taken branches redirect fetch, and any in-flight wrong-path fetch is squashed.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
hazard  in  1  decode stall; buffered instruction must be held
branch_taken  in  1  one-cycle redirect pulse from execute
branch_target  in  XLEN  redirect address, valid with branch_taken
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, stable while imem_req=1 and no ack
imem_ack  in  1  request complete; may arrive in the same cycle as imem_req
imem_rdata  in  XLEN  instruction word, valid with imem_ack
if_valid  out  1  IF/ID buffer holds a valid instruction
if_instr  out  XLEN  buffered instruction
if_pc  out  XLEN  address of if_instr

Behaviour:
- Reset (synchronous, active-high; wins over all inputs): pc=RESET_PC, addr_q=0, state=READY, if_valid=0, if_instr=0, if_pc=0. imem_req is 0 during reset cycles.
- consume = if_valid & ~hazard. can_issue = ~if_valid | consume. Once a request is issued, the buffer is empty or being drained, so an ack never finds the buffer occupied.
- READY (nothing outstanding):
  - imem_req = can_issue & ~branch_taken; imem_addr = pc.
  - Issued with ack in the same cycle: capture, stay READY.
  - Issued without ack: addr_q <= pc, go to BUSY.
- BUSY: imem_req=1, imem_addr=addr_q.
  - Ack without branch: capture, go to READY.
  - Ack with branch: discard rdata, go to READY.
  - Branch without ack: go to FLUSH.
- FLUSH: imem_req=1, imem_addr=addr_q.
  - Ack: discard rdata, go to READY.
  - Branch in FLUSH: pc updates only, and the state stays FLUSH.
- Capture: if_valid<=1, if_instr<=imem_rdata, if_pc<=fetch address, pc<=fetch address+4.
  - Capture latency: the instruction is visible on if_* in the cycle after the ack.
- Consume with no capture in the same cycle: if_valid<=0; if_instr and if_pc keep their values.
- Branch (any state, highest priority after reset):
  - pc<=branch_target; if_valid<=0, squashing the buffered wrong-path instruction even while hazard is asserted.
  - No capture occurs in that cycle.
- With hazard=1 and if_valid=1: if_* hold, pc holds, and no new request issues (unless a branch occurs).
- Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC+4=0. branch_target low bits pass through unchecked.
- Throughput: with a zero-wait memory (ack tied to req) and hazard=0, one instruction per cycle. With N-cycle memory latency, one instruction per N+1 cycles.
- imem_addr is glitch-stable in BUSY/FLUSH; it changes only in READY.

Test Plan:
- Reset, then release with imem_ack tied to imem_req, hazard=0, branch_taken=0 -> imem_addr 0,4,8,… on consecutive cycles; if_pc lags by one cycle; if_valid=1 from cycle 2 onward.
- Hazard=1 for 3 cycles with if_pc=0x8 -> if_pc/if_instr held at 0x8; imem_req=0; after release next if_pc=0xC with no gap.
- imem_ack 3 cycles after request at 0x10 -> imem_addr stays 0x10 for all 3 cycles; state BUSY; if_pc=0x10 one cycle after ack; next request 0x14.
- Branch_taken to 0x100 while BUSY on 0x20, ack 2 cycles later -> FLUSH entered; 0x20 data discarded (if_valid never shows 0x20); next request address 0x100.
- Branch to 0x40 in the same cycle as ack for 0x24, with hazard=1 and if_valid=1 -> if_valid=0 next cycle; 0x24 never captured; next fetch 0x40.
- RESET_PC=32'hFFFF_FFFC, zero-wait memory -> fetches 0xFFFFFFFC then 0x0; reset asserted while BUSY -> next cycle imem_req=0, if_valid=0, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction fetch sequencer with a program counter, an imem
//            req/ack handshake and a single-entry IF/ID buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hazard,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam logic [1:0] c_ready = 2'd0;
    localparam logic [1:0] c_busy  = 2'd1;
    localparam logic [1:0] c_flush = 2'd2;

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_addr_q;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_instr;
    logic [XLEN-1:0] r_if_pc;

    logic            w_consume;
    logic            w_can_issue;
    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_capture;

    assign w_consume   = r_if_valid & ~hazard;
    assign w_can_issue = ~r_if_valid | w_consume;

    // The request is masked while reset is held so nothing leaks out before
    // the state registers have actually been cleared.
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_addr_q;
        if (r_state == c_ready) begin
            w_req  = w_can_issue & ~branch_taken;
            w_addr = r_pc;
        end else begin
            w_req  = 1'b1;
        end
        if (reset) begin
            w_req = 1'b0;
        end
    end

    // Data returned in FLUSH, or alongside a redirect, is wrong-path.
    assign w_capture = imem_ack & ~branch_taken &
                       (((r_state == c_ready) & w_req) | (r_state == c_busy));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ready;
            r_pc       <= RESET_PC[XLEN-1:0];
            r_addr_q   <= '0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            if (branch_taken) begin
                r_pc       <= branch_target;
                r_if_valid <= 1'b0;
            end else if (w_capture) begin
                r_pc       <= w_addr + c_pc_step;
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata;
                r_if_pc    <= w_addr;
            end else if (w_consume) begin
                r_if_valid <= 1'b0;
            end

            case (r_state)
                c_ready: begin
                    if (w_req && !imem_ack) begin
                        r_addr_q <= r_pc;
                        r_state  <= c_busy;
                    end
                end
                c_busy: begin
                    if (imem_ack) begin
                        r_state <= c_ready;
                    end else if (branch_taken) begin
                        r_state <= c_flush;
                    end
                end
                c_flush: begin
                    if (imem_ack) begin
                        r_state <= c_ready;
                    end
                end
                default: begin
                    r_state <= c_ready;
                end
            endcase
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = w_addr;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        hazard;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic        zw;
    logic        ack_m;

    logic        reset2;
    logic        hazard2;
    logic        branch2;
    logic [31:0] target2;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] rdata2;
    logic        if_valid2;
    logic [31:0] if_instr2;
    logic [31:0] if_pc2;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    assign imem_ack   = zw ? imem_req : ack_m;
    assign imem_rdata = mem_word(imem_addr);
    assign rdata2     = mem_word(addr2);

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .hazard        (hazard),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk           (clk),
        .reset         (reset2),
        .hazard        (hazard2),
        .branch_taken  (branch2),
        .branch_target (target2),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_ack      (req2),
        .imem_rdata    (rdata2),
        .if_valid      (if_valid2),
        .if_instr      (if_instr2),
        .if_pc         (if_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        hazard        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        zw            = 1'b1;
        ack_m         = 1'b0;
        reset2        = 1'b1;
        hazard2       = 1'b0;
        branch2       = 1'b0;
        target2       = 32'h0;

        step();
        step();
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
        check_eq("rst_instr", if_instr, 32'h0);
        check_eq("rst_pc", if_pc, 32'h0);

        // zero-wait streaming
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("zw_req", {31'b0, imem_req}, 32'd1);
            check_eq("zw_addr", imem_addr, 32'(4 * i));
            step();
            check_eq("zw_valid", {31'b0, if_valid}, 32'd1);
            check_eq("zw_if_pc", if_pc, 32'(4 * i));
            check_eq("zw_instr", if_instr, mem_word(32'(4 * i)));
        end

        // decode stall holds the buffer and blocks issue
        hazard = 1'b1;
        #1;
        check_eq("hz_req", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hz_if_pc", if_pc, 32'h8);
            check_eq("hz_instr", if_instr, mem_word(32'h8));
            check_eq("hz_req_hold", {31'b0, imem_req}, 32'd0);
        end
        hazard = 1'b0;
        #1;
        check_eq("hz_rel_addr", imem_addr, 32'hC);
        step();
        check_eq("hz_rel_if_pc", if_pc, 32'hC);

        // three-cycle memory latency
        zw = 1'b0;
        #1;
        check_eq("lat_addr0", imem_addr, 32'h10);
        step();
        check_eq("lat_drained", {31'b0, if_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            check_eq("lat_req", {31'b0, imem_req}, 32'd1);
            check_eq("lat_addr", imem_addr, 32'h10);
            step();
        end
        ack_m = 1'b1;
        #1;
        check_eq("lat_addr_ack", imem_addr, 32'h10);
        step();
        ack_m = 1'b0;
        #1;
        check_eq("lat_if_pc", if_pc, 32'h10);
        check_eq("lat_instr", if_instr, mem_word(32'h10));
        check_eq("lat_next_addr", imem_addr, 32'h14);

        // redirect while BUSY leads to FLUSH and the stale word is dropped
        zw = 1'b1;
        step();
        step();
        step();
        check_eq("pre_br_if_pc", if_pc, 32'h1C);
        zw = 1'b0;
        #1;
        check_eq("busy20_addr", imem_addr, 32'h20);
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        #1;
        check_eq("busy20_req", {31'b0, imem_req}, 32'd1);
        step();
        branch_taken = 1'b0;
        #1;
        check_eq("flush_addr", imem_addr, 32'h20);
        check_eq("flush_valid", {31'b0, if_valid}, 32'd0);
        step();
        ack_m = 1'b1;
        step();
        ack_m = 1'b0;
        #1;
        check_eq("flush_discard", {31'b0, if_valid}, 32'd0);
        check_eq("flush_next_addr", imem_addr, 32'h100);
        check_eq("flush_next_req", {31'b0, imem_req}, 32'd1);

        // redirect under hazard squashes the buffered instruction
        branch_taken  = 1'b1;
        branch_target = 32'h20;
        #1;
        check_eq("br_ready_req", {31'b0, imem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        zw = 1'b1;
        step();
        check_eq("sq_if_pc", if_pc, 32'h20);
        hazard        = 1'b1;
        zw            = 1'b0;
        ack_m         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        #1;
        check_eq("sq_req", {31'b0, imem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        ack_m        = 1'b0;
        hazard       = 1'b0;
        #1;
        check_eq("sq_valid", {31'b0, if_valid}, 32'd0);
        check_eq("sq_if_pc_kept", if_pc, 32'h20);
        check_eq("sq_next_addr", imem_addr, 32'h40);

        // ack coinciding with a redirect in BUSY: discard, no FLUSH
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        ack_m         = 1'b1;
        step();
        branch_taken = 1'b0;
        ack_m        = 1'b0;
        #1;
        check_eq("ackbr_valid", {31'b0, if_valid}, 32'd0);
        check_eq("ackbr_addr", imem_addr, 32'h80);
        check_eq("ackbr_req", {31'b0, imem_req}, 32'd1);

        // reset while BUSY
        step();
        reset = 1'b1;
        #1;
        check_eq("rb_req", {31'b0, imem_req}, 32'd0);
        step();
        check_eq("rb_valid", {31'b0, if_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rb_restart_addr", imem_addr, 32'h0);
        check_eq("rb_restart_req", {31'b0, imem_req}, 32'd1);

        // PC wrap-around from the top of the address space
        reset2 = 1'b0;
        #1;
        check_eq("wrap_addr0", addr2, 32'hFFFF_FFFC);
        step();
        check_eq("wrap_if_pc0", if_pc2, 32'hFFFF_FFFC);
        check_eq("wrap_instr0", if_instr2, mem_word(32'hFFFF_FFFC));
        check_eq("wrap_addr1", addr2, 32'h0);
        step();
        check_eq("wrap_if_pc1", if_pc2, 32'h0);
        check_eq("wrap_valid", {31'b0, if_valid2}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
